// File: rtl/tage_index_sched.sv
// tage_index_sched: arbitrates prediction/update lookups and strobes each TAGE bank hash unit in turn.
// Optional macro TAGE_SCHED_BURST_EN: strobe every bank in a single ISSUE cycle instead of walking them.
module tage_index_sched #(
  parameter int NBANK  = 4,
  parameter int pc_len = 32
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              pred_req,
  input  logic [pc_len-1:0] pred_pc,
  output logic              pred_ack,
  input  logic              upd_req,
  input  logic [pc_len-1:0] upd_pc,
  output logic              upd_ack,
  input  logic              flush,
  output logic [pc_len-1:0] hash_pc,
  output logic [NBANK-1:0]  bank_en,
  output logic              busy,
  output logic              done,
  output logic              done_src
);

  localparam int PTR_W = (NBANK > 1) ? $clog2(NBANK) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NBANK - 1);
`ifdef TAGE_SCHED_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, DONE} state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  bank_ptr_q, bank_ptr_d;
  logic [pc_len-1:0] hash_pc_q, hash_pc_d;
  logic [NBANK-1:0]  bank_en_q, bank_en_d;
  logic              pred_ack_q, pred_ack_d;
  logic              upd_ack_q, upd_ack_d;
  logic              done_q, done_d;
  logic              done_src_q, done_src_d;
  logic              busy_q, busy_d;
  logic              last_grant_q, last_grant_d;
  logic              grant_upd;

  // last_grant is 1 for upd; with both requests pending, the source not served last wins
  always_comb begin
    if (pred_req && upd_req) begin
      grant_upd = ~last_grant_q;
    end else begin
      grant_upd = upd_req;
    end
  end

  always_comb begin
    state_d      = state_q;
    bank_ptr_d   = bank_ptr_q;
    hash_pc_d    = hash_pc_q;
    bank_en_d    = '0;
    pred_ack_d   = 1'b0;
    upd_ack_d    = 1'b0;
    done_d       = 1'b0;
    done_src_d   = 1'b0;
    last_grant_d = last_grant_q;

    case (state_q)
      IDLE: begin
        if (!flush && (pred_req || upd_req)) begin
          state_d      = ISSUE;
          bank_ptr_d   = '0;
          hash_pc_d    = grant_upd ? upd_pc : pred_pc;
          bank_en_d    = BURST ? {NBANK{1'b1}} : NBANK'(1);
          pred_ack_d   = ~grant_upd;
          upd_ack_d    = grant_upd;
          last_grant_d = grant_upd;
        end
      end
      ISSUE: begin
        if (flush) begin
          state_d = IDLE;
        end else if (BURST || (bank_ptr_q == LAST_PTR)) begin
          state_d = SETTLE;
        end else begin
          bank_ptr_d = bank_ptr_q + PTR_W'(1);
          bank_en_d  = NBANK'(1) << bank_ptr_d;
        end
      end
      SETTLE: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          state_d    = DONE;
          done_d     = 1'b1;
          done_src_d = last_grant_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      bank_ptr_q   <= '0;
      hash_pc_q    <= '0;
      bank_en_q    <= '0;
      pred_ack_q   <= 1'b0;
      upd_ack_q    <= 1'b0;
      done_q       <= 1'b0;
      done_src_q   <= 1'b0;
      busy_q       <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      bank_ptr_q   <= bank_ptr_d;
      hash_pc_q    <= hash_pc_d;
      bank_en_q    <= bank_en_d;
      pred_ack_q   <= pred_ack_d;
      upd_ack_q    <= upd_ack_d;
      done_q       <= done_d;
      done_src_q   <= done_src_d;
      busy_q       <= busy_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign pred_ack = pred_ack_q;
  assign upd_ack  = upd_ack_q;
  assign hash_pc  = hash_pc_q;
  assign bank_en  = bank_en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign done_src = done_src_q;

endmodule

// File: tb/tb_tage_index_sched.sv
// tb_tage_index_sched: scenario tasks for tage_index_sched; a scoreboard checks every done pulse.
module tb_tage_index_sched;
  localparam int NBANK = 4;
  localparam int PCW   = 32;
`ifdef TAGE_SCHED_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif
  localparam int ISSUE_CYC = BURST ? 1 : NBANK;
  localparam int FLUSH_CYC = BURST ? 1 : 3;

  logic             CLK = 1'b0;
  logic             reset = 1'b0;
  logic             pred_req = 1'b0, upd_req = 1'b0, flush = 1'b0;
  logic [PCW-1:0]   pred_pc = '0, upd_pc = '0;
  logic             pred_ack, upd_ack, busy, done, done_src;
  logic [PCW-1:0]   hash_pc;
  logic [NBANK-1:0] bank_en;

  int n_checks = 0;
  int n_pass = 0;
  logic           exp_src_q[$];
  logic [PCW-1:0] exp_pc_q[$];
  logic           sb_src;
  logic [PCW-1:0] sb_pc;

  tage_index_sched #(.NBANK(NBANK), .pc_len(PCW)) dut (
    .CLK(CLK), .reset(reset),
    .pred_req(pred_req), .pred_pc(pred_pc), .pred_ack(pred_ack),
    .upd_req(upd_req), .upd_pc(upd_pc), .upd_ack(upd_ack),
    .flush(flush), .hash_pc(hash_pc), .bank_en(bank_en),
    .busy(busy), .done(done), .done_src(done_src)
  );

  always #5 CLK = ~CLK;

  // Scoreboard consumer: every done pulse must match the oldest accepted operation
  always @(negedge CLK) begin
    if (done === 1'b1) begin
      n_checks++;
      if (exp_src_q.size() == 0) begin
        $display("FAIL sb_unexpected_done: got done=1 src=%0b pc=%h, required no done", done_src, hash_pc);
      end else begin
        sb_src = exp_src_q.pop_front();
        sb_pc  = exp_pc_q.pop_front();
        if (done_src !== sb_src || hash_pc !== sb_pc)
          $display("FAIL sb_done: got src=%0b pc=%h, required src=%0b pc=%h", done_src, hash_pc, sb_src, sb_pc);
        else n_pass++;
      end
    end
    if (pred_ack === 1'b1 || upd_ack === 1'b1) begin
      n_checks++;
      if (pred_ack === 1'b1 && upd_ack === 1'b1) $display("FAIL ack_exclusive: got both acks high, required one");
      else n_pass++;
    end
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic wait_ack(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (pred_ack === 1'b1 || upd_ack === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) tick();
    n_checks++;
    if ({pred_ack, upd_ack, busy, done, done_src, bank_en, hash_pc} !== '0)
      $display("FAIL reset_outputs: got ack=%b%b busy=%b done=%b src=%b en=%b pc=%h, required all 0",
               pred_ack, upd_ack, busy, done, done_src, bank_en, hash_pc);
    else n_pass++;
    reset = 1'b1;
    repeat (2) tick();
    n_checks++;
    if (busy !== 1'b0 || bank_en !== '0) $display("FAIL idle_after_reset: got busy=%b en=%b, required 0/0", busy, bank_en);
    else n_pass++;
  endtask

  task automatic test_single(input bit src, input logic [PCW-1:0] pc);
    logic [NBANK-1:0] exp_en;
    if (src) begin upd_req = 1'b1; upd_pc = pc; end
    else begin pred_req = 1'b1; pred_pc = pc; end
    tick();
    n_checks++;
    if ({pred_ack, upd_ack} !== (src ? 2'b01 : 2'b10) || hash_pc !== pc)
      $display("FAIL single_ack: got acks=%b%b pc=%h, required acks=%b pc=%h",
               pred_ack, upd_ack, hash_pc, (src ? 2'b01 : 2'b10), pc);
    else n_pass++;
    exp_src_q.push_back(src);
    exp_pc_q.push_back(pc);
    pred_req = 1'b0;
    upd_req  = 1'b0;
    for (int k = 1; k <= ISSUE_CYC + 1; k++) begin
      if (k > 1) tick();
      if (k > ISSUE_CYC) exp_en = '0;
      else if (BURST) exp_en = '1;
      else exp_en = NBANK'(1) << (k - 1);
      n_checks++;
      if (bank_en !== exp_en || busy !== 1'b1 || done !== 1'b0)
        $display("FAIL single_bank_en cycle %0d: got en=%b busy=%b done=%b, required en=%b busy=1 done=0",
                 k, bank_en, busy, done, exp_en);
      else n_pass++;
    end
    tick();
    n_checks++;
    if (done !== 1'b1) $display("FAIL single_done_latency: got done=%b in cycle %0d, required 1", done, ISSUE_CYC + 2);
    else n_pass++;
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) $display("FAIL single_done_pulse: got done=%b busy=%b, required 0/0", done, busy);
    else n_pass++;
  endtask

  task automatic test_contention();
    bit seen;
    tick();
    reset = 1'b0;
    pred_req = 1'b1; upd_req = 1'b1;
    pred_pc = 32'h0000_A000; upd_pc = 32'h0000_B000;
    exp_src_q.delete(); exp_pc_q.delete();
    tick();
    reset = 1'b1;
    tick();
    n_checks++;
    if (pred_ack !== 1'b1 || upd_ack !== 1'b0 || hash_pc !== 32'h0000_A000)
      $display("FAIL contend_first: got acks=%b%b pc=%h, required acks=10 pc=0000a000", pred_ack, upd_ack, hash_pc);
    else n_pass++;
    exp_src_q.push_back(1'b0); exp_pc_q.push_back(32'h0000_A000);
    pred_req = 1'b0;
    wait_done(seen);
    n_checks++; if (!seen) $display("FAIL contend_done1: got timeout, required done"); else n_pass++;
    wait_ack(seen);
    n_checks++;
    if (!seen || upd_ack !== 1'b1 || hash_pc !== 32'h0000_B000)
      $display("FAIL contend_second: got seen=%b upd_ack=%b pc=%h, required 1/1/0000b000", seen, upd_ack, hash_pc);
    else n_pass++;
    exp_src_q.push_back(1'b1); exp_pc_q.push_back(32'h0000_B000);
    upd_req = 1'b0;
    wait_done(seen);
    n_checks++; if (!seen) $display("FAIL contend_done2: got timeout, required done"); else n_pass++;
    pred_req = 1'b1; upd_req = 1'b1;
    pred_pc = 32'h0000_D000; upd_pc = 32'h0000_C000;
    wait_ack(seen);
    n_checks++;
    if (!seen || pred_ack !== 1'b1) $display("FAIL contend_third: got seen=%b pred_ack=%b, required 1/1", seen, pred_ack);
    else n_pass++;
    pred_req = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || bank_en !== '0 || done !== 1'b0)
      $display("FAIL contend_flush: got busy=%b en=%b done=%b, required 0/0/0", busy, bank_en, done);
    else n_pass++;
    pred_req = 1'b1;
    wait_ack(seen);
    n_checks++;
    if (!seen || upd_ack !== 1'b1 || hash_pc !== 32'h0000_C000)
      $display("FAIL contend_after_flush: got seen=%b upd_ack=%b pc=%h, required 1/1/0000c000", seen, upd_ack, hash_pc);
    else n_pass++;
    exp_src_q.push_back(1'b1); exp_pc_q.push_back(32'h0000_C000);
    upd_req = 1'b0;
    wait_done(seen);
    n_checks++; if (!seen) $display("FAIL contend_done3: got timeout, required done"); else n_pass++;
    wait_ack(seen);
    n_checks++;
    if (!seen || pred_ack !== 1'b1 || hash_pc !== 32'h0000_D000)
      $display("FAIL contend_pred_retry: got seen=%b pred_ack=%b pc=%h, required 1/1/0000d000", seen, pred_ack, hash_pc);
    else n_pass++;
    exp_src_q.push_back(1'b0); exp_pc_q.push_back(32'h0000_D000);
    pred_req = 1'b0;
    wait_done(seen);
    n_checks++; if (!seen) $display("FAIL contend_done4: got timeout, required done"); else n_pass++;
    tick();
  endtask

  task automatic test_flush();
    bit seen;
    upd_req = 1'b1; upd_pc = 32'hCAFE_0003;
    tick();
    n_checks++;
    if (upd_ack !== 1'b1) $display("FAIL flush_ack: got upd_ack=%b, required 1", upd_ack);
    else n_pass++;
    upd_req = 1'b0;
    for (int k = 1; k < FLUSH_CYC; k++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++;
    if (bank_en !== '0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL flush_abort: got en=%b busy=%b done=%b, required 0/0/0", bank_en, busy, done);
    else n_pass++;
    repeat (8) tick();
    test_single(1'b0, 32'h0000_0F0F);
  endtask

  task automatic test_reset_mid();
    bit seen;
    pred_req = 1'b1; pred_pc = 32'h1111_2222;
    tick();
    pred_req = 1'b0;
    exp_src_q.push_back(1'b0); exp_pc_q.push_back(32'h1111_2222);
    repeat (ISSUE_CYC) tick();
    n_checks++;
    if (busy !== 1'b1 || bank_en !== '0 || done !== 1'b0)
      $display("FAIL settle_state: got busy=%b en=%b done=%b, required 1/0/0", busy, bank_en, done);
    else n_pass++;
    #2 reset = 1'b0;
    exp_src_q.delete(); exp_pc_q.delete();
    #1;
    n_checks++;
    if ({pred_ack, upd_ack, busy, done, done_src, bank_en, hash_pc} !== '0)
      $display("FAIL async_reset: got busy=%b done=%b en=%b pc=%h, required all 0", busy, done, bank_en, hash_pc);
    else n_pass++;
    tick();
    pred_req = 1'b1; pred_pc = 32'h3333_4444;
    reset = 1'b1;
    tick();
    n_checks++;
    if (pred_ack !== 1'b1 || hash_pc !== 32'h3333_4444)
      $display("FAIL reset_resume: got pred_ack=%b pc=%h, required 1/33334444", pred_ack, hash_pc);
    else n_pass++;
    exp_src_q.push_back(1'b0); exp_pc_q.push_back(32'h3333_4444);
    pred_req = 1'b0;
    wait_done(seen);
    n_checks++; if (!seen) $display("FAIL reset_resume_done: got timeout, required done"); else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    bit seen;
    int gap;
    upd_req = 1'b1; upd_pc = 32'h0000_E000;
    wait_ack(seen);
    n_checks++;
    if (!seen || upd_ack !== 1'b1) $display("FAIL b2b_first: got seen=%b upd_ack=%b, required 1/1", seen, upd_ack);
    else n_pass++;
    exp_src_q.push_back(1'b1); exp_pc_q.push_back(32'h0000_E000);
    upd_pc = 32'h0000_F000;
    gap = 0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      gap++;
      if (upd_ack === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen || gap != ISSUE_CYC + 3 || hash_pc !== 32'h0000_F000)
      $display("FAIL b2b_period: got seen=%b gap=%0d pc=%h, required 1/%0d/0000f000", seen, gap, hash_pc, ISSUE_CYC + 3);
    else n_pass++;
    exp_src_q.push_back(1'b1); exp_pc_q.push_back(32'h0000_F000);
    upd_req = 1'b0;
    wait_done(seen);
    n_checks++; if (!seen) $display("FAIL b2b_done: got timeout, required done"); else n_pass++;
    tick();
  endtask

  initial begin
    test_reset();
    test_single(1'b0, 32'h0000_1234);
    test_single(1'b1, 32'hDEAD_BEEF);
    test_contention();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    repeat (4) tick();
    n_checks++;
    if (exp_src_q.size() != 0) $display("FAIL sb_leftover: got %0d pending, required 0", exp_src_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/tage_index_sched.md
TAGE_INDEX_SCHED -- requirements
Module: tage_index_sched

Interface
REQ-001 Parameter NBANK, default 4, number of tagged banks, one Index_Function-style hash unit per bank, range 1..8.
REQ-002 Parameter pc_len, default 32, program-counter width.
REQ-003 Port CLK  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port pred_req  input  1  prediction lookup request; held high until pred_ack.
REQ-006 Port pred_pc  input  pc_len  lookup PC; stable while pred_req high.
REQ-007 Port pred_ack  output  1  one-cycle acceptance pulse for pred_req.
REQ-008 Port upd_req  input  1  update (retire) request; held high until upd_ack.
REQ-009 Port upd_pc  input  pc_len  update PC; stable while upd_req high.
REQ-010 Port upd_ack  output  1  one-cycle acceptance pulse for upd_req.
REQ-011 Port flush  input  1  synchronous abort of the in-flight operation.
REQ-012 Port hash_pc  output  pc_len  PC driven to every bank hash unit's pc_addr.
REQ-013 Port bank_en  output  NBANK  per-bank index_tag_enable strobes.
REQ-014 Port busy  output  1  high in any state other than IDLE.
REQ-015 Port done  output  1  one-cycle completion pulse.
REQ-016 Port done_src  output  1  source of completed operation (0 = pred, 1 = upd); valid only while done high.

Function
REQ-017 FSM states: IDLE, ISSUE, SETTLE, DONE; all outputs registered.
REQ-018 IDLE: with any request high and flush low, the next edge latches the granted PC into hash_pc, clears bank_ptr to 0, enters ISSUE, and raises the granted ack for exactly that one cycle.
REQ-019 Arbitration: a lone request wins; with both high, grant goes to the source not granted last (last_grant flag, updated on every grant).
REQ-020 Requests are sampled only in IDLE; requests arriving in other states wait, with no loss or duplication.
REQ-021 ISSUE: bank_en is one-hot at bit bank_ptr; bank_ptr increments by 1 per cycle; the cycle with bank_ptr = NBANK-1 moves to SETTLE; bank_ptr never wraps.
REQ-022 SETTLE: one cycle, bank_en all zero (lets the hash registers propagate), then DONE.
REQ-023 DONE: done = 1 and done_src = granted source for one cycle, then IDLE.
REQ-024 Latency: with the request sampled at edge t, ack is high in cycle t+1, bank_en is active in cycles t+1..t+NBANK, and done is high in cycle t+NBANK+2. Back-to-back throughput is one operation per NBANK+3 cycles.
REQ-025 hash_pc holds its value from acceptance until the next acceptance.
REQ-026 flush high in ISSUE, SETTLE or DONE: the next edge goes to IDLE, bank_en = 0, no done pulse (a done pulse already showing in that cycle stands), and last_grant keeps its value.
REQ-027 flush together with a request in IDLE: flush wins; nothing is accepted that cycle.
REQ-028 Outside ISSUE, bank_en is all zero; pred_ack and upd_ack are never high together.

Reset
REQ-029 reset low forces state IDLE, bank_ptr 0, hash_pc 0, bank_en 0, pred_ack 0, upd_ack 0, done 0, done_src 0, busy 0, and last_grant = upd, so the first contended grant goes to pred.
REQ-030 Reset mid-operation abandons the operation with no done pulse; after release the FSM resumes normal sampling on the first edge.

Configuration
REQ-031 Macro TAGE_SCHED_BURST_EN defined: ISSUE lasts exactly one cycle with bank_en all ones, and done falls in cycle t+3.
REQ-032 Macro TAGE_SCHED_BURST_EN undefined: sequential one-hot walk per REQ-021 and REQ-024.

Verification
REQ-033 NBANK=4, macro off, pred_req=1, pred_pc=0x0000_1234 at edge 0: pred_ack in cycle 1; hash_pc=0x1234; bank_en 0001, 0010, 0100, 1000 in cycles 1-4; done=1 with done_src=0 in cycle 6.
REQ-034 pred_req and upd_req both high from reset: pred is granted first, then upd at the next IDLE; after a flush, the next contended grant still alternates per last_grant.
REQ-035 flush pulsed in cycle 3 of an upd operation: bank_en=0 and state IDLE from cycle 4; no done pulse; the next request is accepted normally.
REQ-036 reset asserted in SETTLE: all outputs zero immediately (asynchronous); after release a new pred_req yields pred_ack one cycle later.
REQ-037 Macro on, upd_req with upd_pc=0xDEAD_BEEF: bank_en=1111 for one cycle only; done=1 with done_src=1 two cycles after upd_ack.
